ide_autoconfig: RTL and testbench

Zorro II AutoConfig controller for the IDE card. It presents the card's expansion ROM nibbles at $E80000 while the card sits in the configuration chain, and latches the base address assigned by the OS. Once configured it generates the `ide_access` select consumed by the IDE decode/strobe logic and passes the chain on via `CFGOUT_n`. It is the block that configures and gates the IDE datapath.

---
 rtl/ide_autoconfig.sv | 162 ++++++++++++++++
 tb/tb_ide_autoconfig.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ide_autoconfig.sv
// ide_autoconfig: Zorro II AutoConfig controller for the IDE card.
// Presents the expansion ROM nibbles at $E80000 while the card is unconfigured
// and owns the chain. It latches the base address the OS assigns and drives
// ide_access for the assigned 128 KB window. Once configured or shut up, it
// passes the chain on through CFGOUT_n.
// Optional build macro: IDE_AUTOBOOT_EN (advertises a diag vector and sets er_Type bit4).
//
// Bus handshake: a CPU cycle is active while AS_n is low. RW high marks a read.
// RW low together with UDS_n low marks a write of DIN on D15..D12. Reads are
// answered combinationally and DOE qualifies DOUT. A write is taken on exactly
// one rising CLK edge per AS_n-low cycle: the first qualifying edge. Further
// edges are ignored until AS_n returns high.
module ide_autoconfig #(
    parameter logic [15:0] MANUF_ID   = 16'h144A,
    parameter logic [7:0]  PRODUCT_ID = 8'h05,
    parameter logic [31:0] SERIAL     = 32'h0000_0001
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:1] ADDR,
    input  logic [3:0]  DIN,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        RW,
    input  logic        CFGIN_n,
    output logic [3:0]  DOUT,
    output logic        DOE,
    output logic        CFGOUT_n,
    output logic        configured,
    output logic        ide_access,
    output logic [1:0]  fsm_state
);

`ifdef IDE_AUTOBOOT_EN
    localparam logic [7:0]  ER_TYPE  = 8'hD2;
    localparam logic [15:0] DIAG_VEC = 16'h4000;
`else
    localparam logic [7:0]  ER_TYPE  = 8'hC2;
    localparam logic [15:0] DIAG_VEC = 16'h0000;
`endif

    typedef enum logic [1:0] {
        ST_UNCONFIG   = 2'd0,
        ST_CONFIGURED = 2'd1,
        ST_SHUTUP     = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        wr_done;
    logic [3:0]  base_hi;
    logic [3:0]  base_lo;
    logic        cfgout_q;

    logic        ac_sel;
    logic        rd_sel;
    logic        commit;
    logic        off_base_hi;
    logic        off_base_lo;
    logic        off_shutup;
    logic [6:0]  base;
    logic [7:0]  rom_byte;
    logic [3:0]  rom_nibble;
    logic        rom_invert;

    // A16 is not part of a 128 KB window, and ADDR[15:8] is not decoded inside the
    // AutoConfig page. Both are collected here on purpose.
    logic        unused_bits;
    assign unused_bits = &{1'b0, ADDR[15:8], base_lo[0]};

    // The card answers at $E8xxxx only while unconfigured and the chain grants it.
    assign ac_sel      = (state == ST_UNCONFIG) && !CFGIN_n && !AS_n && (ADDR[23:16] == 8'hE8);
    assign rd_sel      = ac_sel && RW;
    assign commit      = ac_sel && !RW && !UDS_n && !wr_done;
    assign off_base_hi = (ADDR[7:1] == 7'h24);   // $48
    assign off_base_lo = (ADDR[7:1] == 7'h25);   // $4A
    assign off_shutup  = (ADDR[7:1] == 7'h26);   // $4C
    assign base        = {base_hi, base_lo[3:1]};

    // ROM byte lookup: ADDR[7:2] selects the byte and ADDR[1] selects the nibble.
    // Only the low 16 bits of SERIAL fit in the $18-$1E window.
    always_comb begin
        rom_byte = 8'h00;
        case (ADDR[7:2])
            6'h00:   rom_byte = ER_TYPE;          // $00/$02
            6'h01:   rom_byte = PRODUCT_ID;       // $04/$06
            6'h02:   rom_byte = 8'h00;            // $08/$0A flags
            6'h04:   rom_byte = MANUF_ID[15:8];   // $10/$12
            6'h05:   rom_byte = MANUF_ID[7:0];    // $14/$16
            6'h06:   rom_byte = SERIAL[15:8];     // $18/$1A
            6'h07:   rom_byte = SERIAL[7:0];      // $1C/$1E
            6'h0A:   rom_byte = DIAG_VEC[15:8];   // $28/$2A
            6'h0B:   rom_byte = DIAG_VEC[7:0];    // $2C/$2E
            default: rom_byte = 8'h00;
        endcase
    end

    // Even word offset gives the high nibble; offset+2 gives the low nibble. Only er_Type is stored true.
    always_comb begin
        rom_nibble = ADDR[1] ? rom_byte[3:0] : rom_byte[7:4];
        rom_invert = (ADDR[7:2] != 6'h00);
    end

    // State register: reset takes priority over any commit on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_UNCONFIG;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only a committed write while unconfigured can leave UNCONFIG. Both exits are sticky.
    always_comb begin
        state_next = state;
        if (commit) begin
            if (off_base_hi) begin
                state_next = ST_CONFIGURED;
            end else if (off_shutup) begin
                state_next = ST_SHUTUP;
            end
        end
    end

    // Datapath registers: write-once guard, base address nibbles, chain output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_done  <= 1'b0;
            base_hi  <= 4'h0;
            base_lo  <= 4'h0;
            cfgout_q <= 1'b1;
        end else begin
            if (AS_n) begin
                wr_done <= 1'b0;
            end else if (commit) begin
                wr_done <= 1'b1;
            end
            if (commit && off_base_lo) begin
                base_lo <= DIN;
            end
            if (commit && off_base_hi) begin
                base_hi <= DIN;
            end
            // Follows the next state so the chain opens on the commit edge itself.
            cfgout_q <= (state_next == ST_UNCONFIG);
        end
    end

    // Outputs: the read path and the window select are combinational from the bus.
    always_comb begin
        fsm_state  = state;
        configured = (state == ST_CONFIGURED);
        CFGOUT_n   = cfgout_q;
        DOE        = rd_sel;
        DOUT       = 4'h0;
        if (rd_sel) begin
            DOUT = rom_invert ? ~rom_nibble : rom_nibble;
        end
        ide_access = (state == ST_CONFIGURED) && !AS_n && (ADDR[23:17] == base);
    end

endmodule

// File: tb/tb_ide_autoconfig.sv
// tb_ide_autoconfig: directed checks for the AutoConfig ROM, the write commit,
// base window decode, shut-up and reset behaviour.
module tb_ide_autoconfig;

`ifdef IDE_AUTOBOOT_EN
    localparam logic [3:0] EXP_TYPE_HI = 4'hD;
    localparam logic [3:0] EXP_DIAG_HI = 4'hB;
`else
    localparam logic [3:0] EXP_TYPE_HI = 4'hC;
    localparam logic [3:0] EXP_DIAG_HI = 4'hF;
`endif

    logic        CLK;
    logic        RESET;
    logic [23:1] ADDR;
    logic [3:0]  DIN;
    logic        AS_n;
    logic        UDS_n;
    logic        RW;
    logic        CFGIN_n;
    logic [3:0]  DOUT;
    logic        DOE;
    logic        CFGOUT_n;
    logic        configured;
    logic        ide_access;
    logic [1:0]  fsm_state;

    int n_total = 0;
    int n_pass  = 0;

    ide_autoconfig dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADDR       (ADDR),
        .DIN        (DIN),
        .AS_n       (AS_n),
        .UDS_n      (UDS_n),
        .RW         (RW),
        .CFGIN_n    (CFGIN_n),
        .DOUT       (DOUT),
        .DOE        (DOE),
        .CFGOUT_n   (CFGOUT_n),
        .configured (configured),
        .ide_access (ide_access),
        .fsm_state  (fsm_state)
    );

    // Clock: 10 time-unit period
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] addr;
        logic        cfgin_n;
        logic        as_n;
        logic        rw;
        logic        exp_doe;
        logic [3:0]  exp_dout;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        ADDR  = '0;
        DIN   = 4'h0;
        AS_n  = 1'b1;
        UDS_n = 1'b1;
        RW    = 1'b1;
    endtask

    task automatic drive_write(input logic [23:0] addr, input logic [3:0] din);
        ADDR  = addr[23:1];
        DIN   = din;
        AS_n  = 1'b0;
        UDS_n = 1'b0;
        RW    = 1'b0;
    endtask

    // One complete write cycle: AS_n stays low for 'hold' clock edges.
    task automatic bus_write(input logic [23:0] addr, input logic [3:0] din, input int hold);
        @(negedge CLK);
        drive_write(addr, din);
        repeat (hold) @(negedge CLK);
        bus_idle();
        @(negedge CLK);
    endtask

    task automatic bus_read(input string name, input logic [23:0] addr,
                            input logic exp_doe, input logic [3:0] exp_dout);
        @(negedge CLK);
        ADDR  = addr[23:1];
        AS_n  = 1'b0;
        UDS_n = 1'b0;
        RW    = 1'b1;
        #1;
        check({name, " DOE"}, 32'(DOE), 32'(exp_doe));
        check({name, " DOUT"}, 32'(DOUT), 32'(exp_dout));
        @(negedge CLK);
        bus_idle();
    endtask

    task automatic probe(input string name, input logic [23:0] addr, input logic as_n, input logic exp_acc);
        @(negedge CLK);
        ADDR  = addr[23:1];
        AS_n  = as_n;
        UDS_n = 1'b0;
        RW    = 1'b1;
        #1;
        check(name, 32'(ide_access), 32'(exp_acc));
        @(negedge CLK);
        bus_idle();
    endtask

    // Bus-level read vectors in the unconfigured state.
    initial begin
        vecs[0]  = '{24'hE80000, 1'b0, 1'b0, 1'b1, 1'b1, EXP_TYPE_HI};
        vecs[1]  = '{24'hE80002, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2};
        vecs[2]  = '{24'hE80004, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF};
        vecs[3]  = '{24'hE80006, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
        vecs[4]  = '{24'hE80008, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF};
        vecs[5]  = '{24'hE8000A, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF};
        vecs[6]  = '{24'hE80010, 1'b0, 1'b0, 1'b1, 1'b1, 4'hE};
        vecs[7]  = '{24'hE80012, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB};
        vecs[8]  = '{24'hE80014, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB};
        vecs[9]  = '{24'hE80016, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5};
        vecs[10] = '{24'hE80028, 1'b0, 1'b0, 1'b1, 1'b1, EXP_DIAG_HI};
        vecs[11] = '{24'hE8002A, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF};
        vecs[12] = '{24'hE80040, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF};
        vecs[13] = '{24'hE80000, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
        vecs[14] = '{24'hE80000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[15] = '{24'hE90000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    end

    initial begin
        bus_idle();
        CFGIN_n = 1'b0;
        RESET   = 1'b1;

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check("rst configured", 32'(configured), 32'h0);
        check("rst CFGOUT_n", 32'(CFGOUT_n), 32'h1);
        check("rst DOE", 32'(DOE), 32'h0);
        check("rst DOUT", 32'(DOUT), 32'h0);
        check("rst ide_access", 32'(ide_access), 32'h0);
        RESET = 1'b0;

        // ROM read table
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            ADDR    = vecs[i].addr[23:1];
            CFGIN_n = vecs[i].cfgin_n;
            AS_n    = vecs[i].as_n;
            RW      = vecs[i].rw;
            UDS_n   = 1'b0;
            #1;
            check($sformatf("vec%0d DOE", i), 32'(DOE), 32'(vecs[i].exp_doe));
            check($sformatf("vec%0d DOUT", i), 32'(DOUT), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d ide_access", i), 32'(ide_access), 32'h0);
            @(negedge CLK);
            bus_idle();
            CFGIN_n = 1'b0;
        end

        // A write while the chain is not granted is ignored
        CFGIN_n = 1'b1;
        bus_write(24'hE80048, 4'hE, 1);
        #1;
        check("cfgin high configured", 32'(configured), 32'h0);
        check("cfgin high CFGOUT_n", 32'(CFGOUT_n), 32'h1);
        CFGIN_n = 1'b0;

        // base_lo write held 4 clocks, DIN changed mid-cycle: only the first value lands
        @(negedge CLK);
        drive_write(24'hE8004A, 4'h0);
        repeat (2) @(negedge CLK);
        DIN = 4'hE;
        repeat (2) @(negedge CLK);
        bus_idle();
        @(negedge CLK);

        // base_hi write: configured and CFGOUT_n change at the commit edge
        drive_write(24'hE80048, 4'hE);
        #1;
        check("pre-commit configured", 32'(configured), 32'h0);
        check("pre-commit CFGOUT_n", 32'(CFGOUT_n), 32'h1);
        @(posedge CLK);
        #1;
        check("commit configured", 32'(configured), 32'h1);
        check("commit CFGOUT_n", 32'(CFGOUT_n), 32'h0);
        @(negedge CLK);
        DIN = 4'h2;
        repeat (3) @(negedge CLK);
        bus_idle();
        @(negedge CLK);

        // Window decode for base $E00000
        probe("acc E00000", 24'hE00000, 1'b0, 1'b1);
        probe("acc E10000", 24'hE10000, 1'b0, 1'b1);
        probe("acc E20000", 24'hE20000, 1'b0, 1'b0);
        probe("acc EE0000", 24'hEE0000, 1'b0, 1'b0);
        probe("acc 200000", 24'h200000, 1'b0, 1'b0);
        probe("acc AS_n high", 24'hE00000, 1'b1, 1'b0);
        bus_read("cfg read E80000", 24'hE80000, 1'b0, 4'h0);
        check("cfg CFGOUT_n held", 32'(CFGOUT_n), 32'h0);

        // One-cycle reset returns to the unconfigured state
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst2 configured", 32'(configured), 32'h0);
        check("rst2 CFGOUT_n", 32'(CFGOUT_n), 32'h1);
        probe("rst2 acc E00000", 24'hE00000, 1'b0, 1'b0);
        bus_read("rst2 read E80002", 24'hE80002, 1'b1, 4'h2);

        // Reset wins over a commit, then the same AS_n-low cycle commits after reset drops
        @(negedge CLK);
        RESET = 1'b1;
        drive_write(24'hE80048, 4'h6);
        @(posedge CLK);
        #1;
        check("reset wins configured", 32'(configured), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("post-reset pre-edge configured", 32'(configured), 32'h0);
        @(posedge CLK);
        #1;
        check("post-reset commit configured", 32'(configured), 32'h1);
        check("post-reset commit CFGOUT_n", 32'(CFGOUT_n), 32'h0);
        @(negedge CLK);
        bus_idle();
        probe("acc 600000", 24'h600000, 1'b0, 1'b1);
        probe("acc E00000 after rebase", 24'hE00000, 1'b0, 1'b0);

        // Shut-up: chain opens, card never configures
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        bus_write(24'hE8004C, 4'h0, 1);
        #1;
        check("shutup CFGOUT_n", 32'(CFGOUT_n), 32'h0);
        check("shutup configured", 32'(configured), 32'h0);
        probe("shutup acc 000000", 24'h000000, 1'b0, 1'b0);
        bus_write(24'hE80048, 4'hE, 1);
        #1;
        check("shutup late write configured", 32'(configured), 32'h0);
        check("shutup late write CFGOUT_n", 32'(CFGOUT_n), 32'h0);
        bus_read("shutup read E80000", 24'hE80000, 1'b0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
